// File: rtl/sr_lru_arbiter.sv
// sr_lru_arbiter: shares one lru_buffer_one_tact between N requesters.
// Requests are serialised by a three-state FSM (idle, issue, response). The winner's
// payload goes to the buffer during the issue cycle. A pop result is registered into
// rdata and returned with a one-cycle rsp_valid pulse.
// Build option: define SR_LRU_ARB_RR_EN for round-robin arbitration. The default build
// uses fixed priority, where the lowest requester index wins.
module sr_lru_arbiter #(
    parameter int unsigned N    = 2,
    parameter int unsigned DW   = 12,
    parameter int unsigned SW_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      op,
    input  logic [N*DW-1:0]   wdata,
    input  logic [N*SW_W-1:0] sw,
    output logic [N-1:0]      gnt,
    output logic [N-1:0]      rsp_valid,
    output logic [DW-1:0]     rdata,
    output logic              lru_valid_data,
    output logic [DW-1:0]     lru_data,
    output logic [SW_W-1:0]   lru_sw,
    input  logic [DW-1:0]     lru_out
);

    localparam int unsigned SelW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StResp  = 2'd2;

    logic [1:0]      stateQ, stateD;
    logic [SelW-1:0] selQ, selD;
    logic [SelW-1:0] winner;
    logic [DW-1:0]   rdataQ;

    // Per-requester views of the flattened payload buses
    logic [DW-1:0]   wdataArr [N];
    logic [SW_W-1:0] swArr    [N];

    for (genvar g = 0; g < N; g++) begin : gUnpack
        assign wdataArr[g] = wdata[g*DW +: DW];
        assign swArr[g]    = sw[g*SW_W +: SW_W];
    end

`ifdef SR_LRU_ARB_RR_EN
    logic [SelW-1:0] rrPtrQ, rrPtrD;
    logic [SelW-1:0] scanIdx;
    logic            found;

    // Round-robin: first pending request at or after rrPtr, wrapping modulo N
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        scanIdx = '0;
        for (int i = 0; i < N; i++) begin
            if ((int'(rrPtrQ) + i) >= int'(N)) begin
                scanIdx = SelW'(int'(rrPtrQ) + i - int'(N));
            end else begin
                scanIdx = SelW'(int'(rrPtrQ) + i);
            end
            if (!found && req[scanIdx]) begin
                winner = scanIdx;
                found  = 1'b1;
            end
        end
    end

    // Pointer moves one past the requester just served
    always_comb begin
        rrPtrD = rrPtrQ;
        if (stateQ == StIssue) begin
            if (selQ == SelW'(N - 1)) begin
                rrPtrD = '0;
            end else begin
                rrPtrD = selQ + 1'b1;
            end
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtrQ <= '0;
        end else begin
            rrPtrQ <= rrPtrD;
        end
    end
`else
    // Fixed priority: the lowest set request index wins
    always_comb begin
        winner = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = SelW'(i);
            end
        end
    end
`endif

    // Next-state and selection logic
    always_comb begin
        stateD = stateQ;
        selD   = selQ;
        case (stateQ)
            StIdle: begin
                if (|req) begin
                    selD   = winner;
                    stateD = StIssue;
                end
            end
            StIssue: begin
                stateD = op[selQ] ? StResp : StIdle;
            end
            StResp: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // FSM state and selected requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StIdle;
            selQ   <= '0;
        end else begin
            stateQ <= stateD;
            selQ   <= selD;
        end
    end

    // Pop result capture: lru_out is valid at the end of the issue cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdataQ <= '0;
        end else if (stateQ == StIssue && op[selQ]) begin
            rdataQ <= lru_out;
        end
    end

    assign rdata = rdataQ;

    // Grant, response and buffer drive; all zero outside their own state so the
    // buffer never sees a spurious push
    always_comb begin
        gnt            = '0;
        rsp_valid      = '0;
        lru_valid_data = 1'b0;
        lru_data       = '0;
        lru_sw         = '0;
        if (stateQ == StIssue) begin
            gnt[selQ]      = 1'b1;
            lru_data       = wdataArr[selQ];
            lru_sw         = swArr[selQ];
            lru_valid_data = ~op[selQ];
        end
        if (stateQ == StResp) begin
            rsp_valid[selQ] = 1'b1;
        end
    end

endmodule

// File: tb/tb_sr_lru_arbiter.sv
// Directed bench for sr_lru_arbiter (N=2, DW=12, SW_W=2).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_sr_lru_arbiter;

    localparam int unsigned N    = 2;
    localparam int unsigned DW   = 12;
    localparam int unsigned SW_W = 2;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N-1:0]      op;
    logic [N*DW-1:0]   wdata;
    logic [N*SW_W-1:0] sw;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rdata;
    logic              lru_valid_data;
    logic [DW-1:0]     lru_data;
    logic [SW_W-1:0]   lru_sw;
    logic [DW-1:0]     lru_out;

    int nChecks = 0;
    int nPass   = 0;

    sr_lru_arbiter #(
        .N    (N),
        .DW   (DW),
        .SW_W (SW_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .op             (op),
        .wdata          (wdata),
        .sw             (sw),
        .gnt            (gnt),
        .rsp_valid      (rsp_valid),
        .rdata          (rdata),
        .lru_valid_data (lru_valid_data),
        .lru_data       (lru_data),
        .lru_sw         (lru_sw),
        .lru_out        (lru_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            nPass++;
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every output packed into one word: {gnt, rsp_valid, lvd, lru_data, lru_sw, rdata}
    function automatic logic [63:0] allOut();
        return 64'({gnt, rsp_valid, lru_valid_data, lru_data, lru_sw, rdata});
    endfunction

    logic [N-1:0] expGnt [4];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef SR_LRU_ARB_RR_EN
        expGnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        expGnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        rst_n   = 1'b0;
        req     = '0;
        op      = '0;
        wdata   = '0;
        sw      = '0;
        lru_out = '0;

        // Reset then idle
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_outputs", allOut(), 64'd0);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_outputs", allOut(), 64'd0);
            step();
        end

        // Single push from requester 0
        req   = 2'b01;
        op    = 2'b00;
        wdata = {12'h000, 12'hABC};
        sw    = {2'd0, 2'd2};
        @(negedge clk);
        check("push_idle_gnt", 64'(gnt), 64'd0);
        step();
        @(negedge clk);
        check("push_gnt", 64'(gnt), 64'b01);
        check("push_lvd", 64'(lru_valid_data), 64'd1);
        check("push_data", 64'(lru_data), 64'hABC);
        check("push_sw", 64'(lru_sw), 64'd2);
        step();
        req = '0;
        @(negedge clk);
        check("push_after", allOut(), 64'd0);

        // Single pop from requester 1
        step();
        req   = 2'b10;
        op    = 2'b10;
        wdata = {12'h777, 12'h000};
        sw    = {2'd3, 2'd0};
        step();
        lru_out = 12'h123;
        @(negedge clk);
        check("pop_gnt", 64'(gnt), 64'b10);
        check("pop_lvd", 64'(lru_valid_data), 64'd0);
        check("pop_sw", 64'(lru_sw), 64'd3);
        check("pop_data", 64'(lru_data), 64'h777);
        check("pop_no_rsp_yet", 64'(rsp_valid), 64'd0);
        step();
        req     = '0;
        lru_out = '0;
        @(negedge clk);
        check("pop_rsp", 64'(rsp_valid), 64'b10);
        check("pop_rdata", 64'(rdata), 64'h123);
        check("pop_rsp_gnt", 64'(gnt), 64'd0);
        step();
        @(negedge clk);
        check("pop_rsp_end", 64'(rsp_valid), 64'd0);
        check("pop_rdata_hold", 64'(rdata), 64'h123);

        // Contention: both push, both keep requesting
        step();
        req   = 2'b11;
        op    = 2'b00;
        wdata = {12'h222, 12'h111};
        sw    = {2'd1, 2'd0};
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check("cont_idle_gnt", 64'(gnt), 64'd0);
            step();
            @(negedge clk);
            check("cont_gnt", 64'(gnt), 64'(expGnt[t]));
            check("cont_data", 64'(lru_data), (expGnt[t] == 2'b01) ? 64'h111 : 64'h222);
            step();
        end
        req = '0;
        @(negedge clk);
        check("cont_done", 64'(gnt), 64'd0);

        // Reset during the issue cycle of a pop
        step();
        req = 2'b10;
        op  = 2'b10;
        sw  = {2'd1, 2'd0};
        step();
        lru_out = 12'h3C3;
        @(negedge clk);
        check("rst_pop_gnt", 64'(gnt), 64'b10);
        #2;
        rst_n = 1'b0;
        req   = '0;
        #1;
        check("rst_pop_async", allOut(), 64'd0);
        step();
        @(negedge clk);
        check("rst_pop_no_rsp", 64'(rsp_valid), 64'd0);
        check("rst_pop_rdata", 64'(rdata), 64'd0);
        step();
        rst_n   = 1'b1;
        lru_out = '0;
        @(negedge clk);
        check("rst_pop_idle", allOut(), 64'd0);
        step();
        req = 2'b10;
        op  = 2'b10;
        sw  = {2'd1, 2'd0};
        step();
        lru_out = 12'h456;
        @(negedge clk);
        check("repop_gnt", 64'(gnt), 64'b10);
        step();
        req     = '0;
        lru_out = '0;
        @(negedge clk);
        check("repop_rsp", 64'(rsp_valid), 64'b10);
        check("repop_rdata", 64'(rdata), 64'h456);

        // Back-to-back push (req 0) then pop (req 1)
        step();
        req   = 2'b01;
        op    = 2'b10;
        wdata = {12'h000, 12'h5A5};
        sw    = {2'd1, 2'd1};
        step();
        @(negedge clk);
        check("b2b_push_gnt", 64'(gnt), 64'b01);
        check("b2b_push_lvd", 64'(lru_valid_data), 64'd1);
        check("b2b_push_data", 64'(lru_data), 64'h5A5);
        check("b2b_push_sw", 64'(lru_sw), 64'd1);
        step();
        req = 2'b10;
        @(negedge clk);
        check("b2b_push_done", 64'(gnt), 64'd0);
        check("b2b_no_rsp", 64'(rsp_valid), 64'd0);
        step();
        lru_out = 12'h5A5;
        @(negedge clk);
        check("b2b_pop_gnt", 64'(gnt), 64'b10);
        check("b2b_pop_lvd", 64'(lru_valid_data), 64'd0);
        check("b2b_pop_sw", 64'(lru_sw), 64'd1);
        step();
        req     = '0;
        lru_out = '0;
        @(negedge clk);
        check("b2b_pop_rsp", 64'(rsp_valid), 64'b10);
        check("b2b_pop_rdata", 64'(rdata), 64'h5A5);
        step();
        @(negedge clk);
        check("b2b_final", 64'({gnt, rsp_valid, lru_valid_data}), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
